// File: rtl/sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq
// Sequential AES SubBytes / InvSubBytes engine for one 128-bit state.
// LANES S-box lanes are time-shared across the 16 state bytes, so a block
// takes STEPS = 16/LANES substitution cycles. The encrypt/decrypt mode is
// captured with each block and travels with it to the output.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_flush  : synchronous abort of the block in flight (wins over handshakes)
//   i_valid  : input block valid
//   o_ready  : engine accepts a block this cycle
//   i_mode   : 0 = encrypt (S-box), 1 = decrypt (inverse S-box)
//   i_data   : input state, byte 15 = [127:120] ... byte 0 = [7:0]
//   o_valid  : result valid, held until accepted
//   i_ready  : downstream accepts the result
//   o_mode   : mode captured with this block
//   o_data   : substituted state (registered)
//   o_busy   : high while substituting
// -----------------------------------------------------------------------------
module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_mode,
  input  logic [127:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_mode,
  output logic [127:0] o_data,
  output logic         o_busy
);

  localparam int STEPS = 16 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Tables are stored with entry 0 in the top byte, so entry x lives at
  // element 255-x, which for an 8-bit index is simply ~x.
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0][7:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    data_q, data_d;
  logic            mode_q, mode_d;

  logic [3:0]      lane_idx [LANES];
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];

  // Step k works on bytes 15-k*LANES downward, most significant byte first.
  // The table is chosen by the captured mode, never the live input.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_idx[gi] = 4'(15 - gi - LANES * int'(cnt_q));
    assign lane_in[gi]  = data_q[{lane_idx[gi], 3'b000} +: 8];
    assign lane_out[gi] = mode_q ? INV_TBL[~lane_in[gi]] : SBOX_TBL[~lane_in[gi]];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode_d  = mode_q;
    o_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          data_d  = i_data;
          mode_d  = i_mode;
          cnt_d   = '0;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        for (int l = 0; l < LANES; l++) begin
          data_d[{lane_idx[l], 3'b000} +: 8] = lane_out[l];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS - 1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Ready passes straight through so a new block can enter in the
        // same cycle the finished one leaves.
        o_ready = i_ready;
        if (i_ready) begin
          if (i_valid) begin
            data_d  = i_data;
            mode_d  = i_mode;
            cnt_d   = '0;
            state_d = S_SUB;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including an accept in the same cycle.
    if (i_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      data_d  = data_q;
      mode_d  = mode_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  assign o_valid = (state_q == S_HOLD);
  assign o_busy  = (state_q == S_SUB);
  assign o_data  = data_q;
  assign o_mode  = mode_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
module tb_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_mode = 1'b0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         dut_ready, dut_valid, dut_mode, dut_busy;
  logic [127:0] dut_data;

  // sweep instances LANES = 1, 2, 8, 16 share one input side
  logic         sw_valid = 1'b0;
  logic         sw_mode = 1'b0;
  logic [127:0] sw_data = '0;
  logic         sw_rdy = 1'b0;
  logic         sw_o_ready [4];
  logic         sw_o_valid [4];
  logic         sw_o_mode  [4];
  logic         sw_o_busy  [4];
  logic [127:0] sw_o_data  [4];

  int passed = 0;
  int total  = 0;

  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];

  localparam logic [127:0] T1_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] T1_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;

  sub_bytes_seq #(.LANES(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(dut_ready),
    .i_mode(in_mode), .i_data(in_data), .o_valid(dut_valid), .i_ready(out_ready),
    .o_mode(dut_mode), .o_data(dut_data), .o_busy(dut_busy)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    sub_bytes_seq #(.LANES(gi == 3 ? 16 : (gi == 2 ? 8 : gi + 1))) u_sw (
      .i_clk(clk), .i_rst(rst), .i_flush(1'b0), .i_valid(sw_valid), .o_ready(sw_o_ready[gi]),
      .i_mode(sw_mode), .i_data(sw_data), .o_valid(sw_o_valid[gi]), .i_ready(sw_rdy),
      .o_mode(sw_o_mode[gi]), .o_data(sw_o_data[gi]), .o_busy(sw_o_busy[gi])
    );
  end

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // GF(2^8) multiply, AES polynomial
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // reference tables from the field inverse plus affine transform
  task automatic build_ref();
    logic [7:0] iv, s;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
        end
      end
      s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
      ref_fwd[x] = s;
      ref_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_block(input logic m, input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      r[b*8 +: 8] = m ? ref_inv[d[b*8 +: 8]] : ref_fwd[d[b*8 +: 8]];
    end
    return r;
  endfunction

  // Drive one block through the main DUT from IDLE; returns observed latency
  // (-1 on timeout), data and mode, then completes the output handshake.
  task automatic do_block(input logic m, input logic [127:0] d,
                          output int lat, output logic [127:0] q, output logic qm);
    int guard;
    guard = 0;
    while (!dut_ready && guard < 50) begin tick(); guard++; end
    in_valid = 1'b1; in_mode = m; in_data = d;
    tick();
    in_valid = 1'b0; in_mode = ~m; in_data = '0;
    lat = 0;
    while (!dut_valid && lat < 50) begin tick(); lat++; end
    if (!dut_valid) lat = -1;
    q = dut_data; qm = dut_mode;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("blk mode=%0d in=%h out=%h lat=%0d", m, d, q, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (dut_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dut_valid); else passed++;
    total++; if (dut_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", dut_busy); else passed++;
    total++; if (dut_data !== 128'h0) $display("FAIL reset_data: got %h want 0", dut_data); else passed++;
    total++; if (dut_mode !== 1'b0) $display("FAIL reset_mode: got %b want 0", dut_mode); else passed++;
    rst = 1'b0;
    tick();
    total++; if (dut_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", dut_ready); else passed++;
  endtask

  task automatic test_encrypt();
    int lat; logic [127:0] q; logic qm;
    do_block(1'b0, T1_IN, lat, q, qm);
    total++; if (lat !== 4) $display("FAIL enc_latency: got %0d want 4", lat); else passed++;
    total++; if (q !== T1_OUT) $display("FAIL enc_data: got %h want %h", q, T1_OUT); else passed++;
    total++; if (qm !== 1'b0) $display("FAIL enc_mode: got %b want 0", qm); else passed++;
    total++; if (dut_valid !== 1'b0) $display("FAIL enc_release: got valid %b want 0", dut_valid); else passed++;
  endtask

  task automatic test_decrypt();
    int lat; logic [127:0] q; logic qm;
    do_block(1'b1, T1_OUT, lat, q, qm);
    total++; if (q !== T1_IN) $display("FAIL dec_data: got %h want %h", q, T1_IN); else passed++;
    total++; if (qm !== 1'b1) $display("FAIL dec_mode: got %b want 1", qm); else passed++;
    do_block(1'b0, {16{8'h00}}, lat, q, qm);
    total++; if (q !== {16{8'h63}}) $display("FAIL enc_zero: got %h want %h", q, {16{8'h63}}); else passed++;
    do_block(1'b1, {16{8'h63}}, lat, q, qm);
    total++; if (q !== {16{8'h00}}) $display("FAIL dec_63: got %h want %h", q, {16{8'h00}}); else passed++;
    total++; if (lat !== 4) $display("FAIL dec_latency: got %0d want 4", lat); else passed++;
  endtask

  task automatic test_back_to_back();
    int g, lat;
    in_valid = 1'b1; in_mode = 1'b0; in_data = T1_IN;
    tick();
    in_data = {16{8'h53}};  // next block waits with valid high
    g = 0;
    while (!dut_valid && g < 50) begin tick(); g++; end
    total++; if (dut_valid !== 1'b1) $display("FAIL bp_reach_hold: got valid %b want 1", dut_valid); else passed++;
    for (int i = 0; i < 10; i++) begin
      total++; if (dut_data !== T1_OUT) $display("FAIL bp_data_c%0d: got %h want %h", i, dut_data, T1_OUT); else passed++;
      total++; if (dut_ready !== 1'b0) $display("FAIL bp_ready_c%0d: got %b want 0", i, dut_ready); else passed++;
      total++; if (dut_valid !== 1'b1) $display("FAIL bp_valid_c%0d: got %b want 1", i, dut_valid); else passed++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (dut_ready !== 1'b1) $display("FAIL bp_passthru_ready: got %b want 1", dut_ready); else passed++;
    tick();
    out_ready = 1'b0; in_valid = 1'b0; in_mode = 1'b1; in_data = '0;
    total++; if (dut_busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", dut_busy); else passed++;
    total++; if (dut_valid !== 1'b0) $display("FAIL b2b_valid_drop: got %b want 0", dut_valid); else passed++;
    lat = 0;
    while (!dut_valid && lat < 50) begin tick(); lat++; end
    total++; if (lat !== 4) $display("FAIL b2b_latency: got %0d want 4", lat); else passed++;
    total++; if (dut_data !== {16{8'hed}}) $display("FAIL b2b_data: got %h want %h", dut_data, {16{8'hed}}); else passed++;
    total++; if (dut_mode !== 1'b0) $display("FAIL b2b_mode: got %b want 0", dut_mode); else passed++;
    $display("blk b2b mode=0 out=%h lat=%0d", dut_data, lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (dut_valid !== 1'b0) $display("FAIL b2b_release: got %b want 0", dut_valid); else passed++;
  endtask

  task automatic test_flush();
    int g, lat; logic seen; logic [127:0] q; logic qm;
    in_valid = 1'b1; in_mode = 1'b0; in_data = T1_IN;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1; in_valid = 1'b1; in_data = {16{8'h11}};
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (dut_busy !== 1'b0) $display("FAIL flush_sub_busy: got %b want 0", dut_busy); else passed++;
    total++; if (dut_ready !== 1'b1) $display("FAIL flush_sub_ready: got %b want 1", dut_ready); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin seen = seen | dut_valid; tick(); end
    total++; if (seen !== 1'b0) $display("FAIL flush_no_valid: got %b want 0", seen); else passed++;
    // accept attempted in IDLE together with flush must be ignored
    flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (dut_busy !== 1'b0) $display("FAIL flush_idle_accept: got busy %b want 0", dut_busy); else passed++;
    do_block(1'b0, {16{8'h53}}, lat, q, qm);
    total++; if (q !== {16{8'hed}}) $display("FAIL flush_next_data: got %h want %h", q, {16{8'hed}}); else passed++;
    total++; if (lat !== 4) $display("FAIL flush_next_latency: got %0d want 4", lat); else passed++;
    // flush in HOLD beats a simultaneous output handshake and new accept
    in_valid = 1'b1; in_data = T1_IN;
    tick();
    in_valid = 1'b0;
    g = 0;
    while (!dut_valid && g < 50) begin tick(); g++; end
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    total++; if (dut_valid !== 1'b0) $display("FAIL flush_hold_valid: got %b want 0", dut_valid); else passed++;
    total++; if (dut_busy !== 1'b0) $display("FAIL flush_hold_busy: got %b want 0", dut_busy); else passed++;
  endtask

  task automatic test_async_reset();
    int g, lat; logic [127:0] q; logic qm;
    in_valid = 1'b1; in_mode = 1'b1; in_data = T1_OUT;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    total++; if (dut_busy !== 1'b0) $display("FAIL arst_sub_busy: got %b want 0", dut_busy); else passed++;
    total++; if (dut_valid !== 1'b0) $display("FAIL arst_sub_valid: got %b want 0", dut_valid); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    total++; if (dut_ready !== 1'b1) $display("FAIL arst_sub_ready: got %b want 1", dut_ready); else passed++;
    total++; if (dut_data !== 128'h0) $display("FAIL arst_sub_data: got %h want 0", dut_data); else passed++;
    in_valid = 1'b1; in_mode = 1'b1; in_data = T1_OUT;
    tick();
    in_valid = 1'b0;
    g = 0;
    while (!dut_valid && g < 50) begin tick(); g++; end
    #2 rst = 1'b1;
    #1;
    total++; if (dut_valid !== 1'b0) $display("FAIL arst_hold_valid: got %b want 0", dut_valid); else passed++;
    total++; if (dut_mode !== 1'b0) $display("FAIL arst_hold_mode: got %b want 0", dut_mode); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    total++; if (dut_ready !== 1'b1) $display("FAIL arst_hold_ready: got %b want 1", dut_ready); else passed++;
    do_block(1'b0, T1_IN, lat, q, qm);
    total++; if (q !== T1_OUT) $display("FAIL arst_after_data: got %h want %h", q, T1_OUT); else passed++;
  endtask

  task automatic test_lane_sweep();
    logic [127:0] blk, exp_q;
    logic [127:0] got [4];
    logic         gm  [4];
    int           lat [4];
    int           exp_lat, g;
    logic         all_done;
    for (int md = 0; md < 2; md++) begin
      for (int j = 0; j < 16; j++) begin
        for (int b = 0; b < 16; b++) blk[b*8 +: 8] = 8'(j * 16 + b);
        exp_q = ref_block(md[0], blk);
        g = 0;
        while (!(sw_o_ready[0] && sw_o_ready[1] && sw_o_ready[2] && sw_o_ready[3]) && g < 50) begin
          tick(); g++;
        end
        sw_valid = 1'b1; sw_mode = md[0]; sw_data = blk;
        tick();
        sw_valid = 1'b0; sw_mode = ~md[0]; sw_data = '0;
        for (int k = 0; k < 4; k++) begin lat[k] = -1; got[k] = 'x; gm[k] = 1'bx; end
        for (int c = 0; c < 40; c++) begin
          all_done = 1'b1;
          for (int k = 0; k < 4; k++) begin
            if (lat[k] < 0 && sw_o_valid[k]) begin
              lat[k] = c; got[k] = sw_o_data[k]; gm[k] = sw_o_mode[k];
            end
            if (lat[k] < 0) all_done = 1'b0;
          end
          if (all_done) break;
          tick();
        end
        for (int k = 0; k < 4; k++) begin
          exp_lat = (k == 0) ? 16 : (k == 1) ? 8 : (k == 2) ? 2 : 1;
          total++; if (lat[k] !== exp_lat) $display("FAIL sweep_lat_i%0d_m%0d_b%0d: got %0d want %0d", k, md, j, lat[k], exp_lat); else passed++;
          total++; if (got[k] !== exp_q) $display("FAIL sweep_data_i%0d_m%0d_b%0d: got %h want %h", k, md, j, got[k], exp_q); else passed++;
          total++; if (gm[k] !== md[0]) $display("FAIL sweep_mode_i%0d_m%0d_b%0d: got %b want %b", k, md, j, gm[k], md[0]); else passed++;
        end
        $display("sweep mode=%0d in=%h exp=%h lat=%0d/%0d/%0d/%0d", md, blk, exp_q, lat[0], lat[1], lat[2], lat[3]);
        sw_rdy = 1'b1;
        tick();
        sw_rdy = 1'b0;
      end
    end
  endtask

  initial begin
    build_ref();
    tick();
    test_reset();
    test_encrypt();
    test_decrypt();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_lane_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
